// File: rtl/bypass_pipe_pkg.sv
// bypass_pipe_pkg: bypass record layout {VAL, TAG, DATA} shared by issue and writeback blocks.
package bypass_pipe_pkg;
   function automatic int byp_rec_w(input int wr, input int xl);
      return 1 + wr + xl;
   endfunction
   function automatic int byp_tag_lsb(input int xl);
      return xl;
   endfunction
   function automatic int byp_val_bit(input int wr, input int xl);
      return wr + xl;
   endfunction
endpackage

// File: rtl/bypass_sel.sv
// bypass_sel: per-operand priority match; the highest-index valid candidate with a matching tag wins.
module bypass_sel #(
   parameter int WR   = 5,
   parameter int XLEN = 32,
   parameter int N    = 21,
   parameter int ZERO = 1
) (
   input  logic [WR-1:0]     i_rs,
   input  logic [XLEN-1:0]   i_dflt,
   input  logic [N-1:0]      i_val,
   input  logic [N*WR-1:0]   i_tag,
   input  logic [N*XLEN-1:0] i_data,
   output logic [XLEN-1:0]   o_data
);
   logic w_zero;
   assign w_zero = (ZERO != 0) && (i_rs == '0);
   always_comb begin
      o_data = i_dflt;
      for (int k = 0; k < N; k++)
         if (i_val[k] && !w_zero && i_tag[k*WR +: WR] == i_rs) o_data = i_data[k*XLEN +: XLEN];
   end
endmodule

// File: rtl/bypass_pipe.sv
// bypass_pipe: operand stage resolving register-file reads against current and recent bypass results.
// Candidates are ordered oldest history row first, current sources last, so a plain last-match scan gives priority.
module bypass_pipe
   import bypass_pipe_pkg::*;
#(
   parameter int WIDTH_REG = 5,
   parameter int XLEN      = 32,
   parameter int NPORT     = 4,
   parameter int NBYP      = 7,
   parameter int HIST      = 2,
   parameter int ZERO_P0   = 1
) (
   input  logic                                   i_clk,
   input  logic                                   i_rst_n,
   input  logic                                   i_valid,
   output logic                                   o_ready,
   input  logic [NPORT*2*WIDTH_REG-1:0]           i_irs,
   input  logic [NPORT*2*XLEN-1:0]                i_regFile,
   input  logic [NBYP*byp_rec_w(WIDTH_REG,XLEN)-1:0] i_bypass,
   input  logic                                   i_flush,
   output logic                                   o_valid,
   input  logic                                   i_ready,
   output logic [NPORT*2*XLEN-1:0]                o_data
);
   localparam int RW  = byp_rec_w(WIDTH_REG, XLEN);
   localparam int NOP = NPORT * 2;
   localparam int NH  = HIST * NBYP;
   localparam int NC  = NH + NBYP;

   logic                      r_valid;
   logic [NOP*XLEN-1:0]       r_data;
   logic [NOP*WIDTH_REG-1:0]  r_tag;
   logic [NH-1:0]             r_hv;
   logic [NH*WIDTH_REG-1:0]   r_ht;
   logic [NH*XLEN-1:0]        r_hd;
   logic [NBYP-1:0]           w_cv;
   logic [NBYP*WIDTH_REG-1:0] w_ct;
   logic [NBYP*XLEN-1:0]      w_cd;
   logic [NC-1:0]             w_kv;
   logic [NC*WIDTH_REG-1:0]   w_kt;
   logic [NC*XLEN-1:0]        w_kd;
   logic [NOP*XLEN-1:0]       w_sel;
   logic                      w_stall;
   logic                      w_accept;

   assign o_ready  = (!r_valid || i_ready) && !i_flush;
   assign o_valid  = r_valid;
   assign o_data   = r_data;
   assign w_stall  = r_valid && !i_ready;
   assign w_accept = i_valid && o_ready;

   genvar a, b, g;
   generate
      for (b = 0; b < NBYP; b++) begin : g_cur
         assign w_cv[b]                        = i_bypass[b*RW + byp_val_bit(WIDTH_REG, XLEN)];
         assign w_ct[b*WIDTH_REG +: WIDTH_REG] = i_bypass[b*RW + byp_tag_lsb(XLEN) +: WIDTH_REG];
         assign w_cd[b*XLEN +: XLEN]           = i_bypass[b*RW +: XLEN];
         assign w_kv[NH+b]                         = w_cv[b];
         assign w_kt[(NH+b)*WIDTH_REG +: WIDTH_REG] = w_ct[b*WIDTH_REG +: WIDTH_REG];
         assign w_kd[(NH+b)*XLEN +: XLEN]           = w_cd[b*XLEN +: XLEN];
      end
      // History is invisible while stalled: held operands refresh from current sources only.
      for (a = 0; a < HIST; a++) begin : g_age
         for (b = 0; b < NBYP; b++) begin : g_src
            assign w_kv[(HIST-1-a)*NBYP+b] = r_hv[a*NBYP+b] && !w_stall;
            assign w_kt[((HIST-1-a)*NBYP+b)*WIDTH_REG +: WIDTH_REG] = r_ht[(a*NBYP+b)*WIDTH_REG +: WIDTH_REG];
            assign w_kd[((HIST-1-a)*NBYP+b)*XLEN +: XLEN]           = r_hd[(a*NBYP+b)*XLEN +: XLEN];
         end
      end
      for (g = 0; g < NOP; g++) begin : g_op
         bypass_sel #(.WR(WIDTH_REG), .XLEN(XLEN), .N(NC), .ZERO(ZERO_P0)) u_sel (
            .i_rs   (w_stall ? r_tag[g*WIDTH_REG +: WIDTH_REG] : i_irs[g*WIDTH_REG +: WIDTH_REG]),
            .i_dflt (w_stall ? r_data[g*XLEN +: XLEN] : i_regFile[g*XLEN +: XLEN]),
            .i_val  (w_kv),
            .i_tag  (w_kt),
            .i_data (w_kd),
            .o_data (w_sel[g*XLEN +: XLEN])
         );
      end
   endgenerate

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_valid <= 1'b0;
         r_data  <= '0;
         r_tag   <= '0;
         r_hv    <= '0;
         r_ht    <= '0;
         r_hd    <= '0;
      end else if (i_flush) begin
         r_valid <= 1'b0;
         r_hv    <= '0;
      end else begin
         r_valid <= w_accept || w_stall;
         if (w_accept || w_stall) r_data <= w_sel;
         if (w_accept) r_tag <= i_irs;
         for (int k = HIST - 1; k > 0; k--) begin
            r_hv[k*NBYP +: NBYP]                     <= r_hv[(k-1)*NBYP +: NBYP];
            r_ht[k*NBYP*WIDTH_REG +: NBYP*WIDTH_REG] <= r_ht[(k-1)*NBYP*WIDTH_REG +: NBYP*WIDTH_REG];
            r_hd[k*NBYP*XLEN +: NBYP*XLEN]           <= r_hd[(k-1)*NBYP*XLEN +: NBYP*XLEN];
         end
         r_hv[0 +: NBYP]           <= w_cv;
         r_ht[0 +: NBYP*WIDTH_REG] <= w_ct;
         r_hd[0 +: NBYP*XLEN]      <= w_cd;
      end
   end
endmodule

// File: doc/bypass_pipe.md
BYPASS_PIPE -- requirements
Module: bypass_pipe

Interface
REQ-001 Parameter WIDTH_REG, default 5, physical register tag width.
REQ-002 Parameter XLEN, default 32, operand data width.
REQ-003 Parameter NPORT, default 4, number of issue ports; each port has 2 operands (RS1, RS2).
REQ-004 Parameter NBYP, default 7, number of bypass sources per cycle.
REQ-005 Parameter HIST, default 2, number of past cycles of bypass results retained (1..4).
REQ-006 Parameter ZERO_P0, default 1; when 1, tag 0 is never bypassed.
REQ-007 i_clk  in  1  sole clock; all state updates on rising edge.
REQ-008 i_rst_n  in  1  reset, asynchronous, active-low.
REQ-009 i_valid  in  1  input operand set valid.
REQ-010 o_ready  out  1  stage can accept the input set.
REQ-011 i_irs  in  NPORT*2*WIDTH_REG  tags; port p = {RS2,RS1} at slice p.
REQ-012 i_regFile  in  NPORT*2*XLEN  register-file read data, same packing as i_irs.
REQ-013 i_bypass  in  NBYP*(1+WIDTH_REG+XLEN)  source b = {VAL, TAG, DATA} at slice b.
REQ-014 i_flush  in  1  discard held operands and history.
REQ-015 o_valid  out  1  output operand set valid.
REQ-016 i_ready  in  1  consumer accepts output set.
REQ-017 o_data  out  NPORT*2*XLEN  resolved operands, same packing as i_regFile.

Function
REQ-018 o_ready SHALL equal (!o_valid || i_ready) && !i_flush.
REQ-019 An accept occurs when i_valid && o_ready; the set SHALL be registered, o_valid high the next cycle (latency 1).
REQ-020 Per operand at accept: value = highest-index current source b with VAL && TAG==rs; else youngest matching history entry (highest index within same age); else i_regFile value.
REQ-021 With ZERO_P0=1, operands with rs==0 SHALL take i_regFile value regardless of bypasses or history.
REQ-022 While o_valid && !i_ready (stall), each held operand SHALL be overwritten by a matching current bypass (highest index wins); tag held unchanged.
REQ-023 When o_valid && i_ready && !i_valid, o_valid SHALL clear next cycle; o_data holds its last value.
REQ-024 History SHALL shift every cycle: age-0 row loads all NBYP current sources, age HIST-1 row is dropped; entries with VAL=0 never match.
REQ-025 i_flush SHALL clear o_valid and all history VAL bits next cycle; no accept occurs in a flush cycle; current bypasses in the flush cycle are not recorded.
REQ-026 A tag appearing in both current sources and history SHALL resolve to the current source.
REQ-027 Multiple sources with identical tag in one cycle: highest index SHALL win, both for accept and for stall refresh.

Reset
REQ-028 On i_rst_n low, o_valid SHALL be 0, o_data all-zero, all history VAL bits 0, immediately and without clock.
REQ-029 o_ready SHALL be 1 during and after reset when i_flush is low.
REQ-030 Reset asserted mid-stall SHALL drop the held set; no output after deassertion until a new accept.

Structure
REQ-031 Bypass record field widths (VAL, TAG, DATA offsets) and packing helpers SHALL live in a shared package/header used by the issue and writeback blocks.
REQ-032 Per-operand priority match SHALL be one combinational sub-module, bypass_sel, instantiated NPORT*2 times; bypass_pipe owns all registers.

Verification
REQ-033 Accept with rs1=5, regfile=0x11, source 2 {1,5,0xAA}, source 6 {1,5,0xBB} -> next cycle o_valid=1, operand=0xBB.
REQ-034 Cycle n source 0 {1,9,0x42}; cycle n+1 accept rs2=9, regfile=0x0 -> operand 0x42; repeat with HIST=2 at cycle n+3 -> operand=regfile value.
REQ-035 Accept rs1=3 (regfile 0x1), i_ready=0 two cycles, source 4 {1,3,0x77} in second stall cycle -> on release operand 0x77.
REQ-036 rs1=0, source 0 {1,0,0xFF}, ZERO_P0=1 -> operand=regfile value.
REQ-037 Held valid set, i_flush=1 with i_valid=1 -> o_ready=0, o_valid=0 next cycle, later history lookup for flushed tags returns regfile value.
REQ-038 Assert i_rst_n=0 asynchronously mid-stall -> o_valid=0 and o_data=0 before next clock edge; o_ready=1.
